// File: rtl/chroma_key_mixer.sv
// chroma_key_mixer: joins fg/bg Avalon-ST RGB streams beat-for-beat and replaces green-screen fg pixels with bg
// Ports: clk, reset_n (async, active low); fg_*/bg_* sink streams ({R,G,B}, R in MSBs);
//   out_* source stream (readyLatency 0); key_en/key_g_min/key_margin live key thresholds;
//   sync_err sticky fg/bg packet misalignment flag.
// Option: define CHROMA_KEY_STATS_EN to add keyed_count/count_valid per-video-frame keyed pixel stats.
module chroma_key_mixer #(
  parameter int CW = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [3*CW-1:0] fg_data,
  input  logic            fg_sop,
  input  logic            fg_eop,
  input  logic            fg_valid,
  output logic            fg_ready,
  input  logic [3*CW-1:0] bg_data,
  input  logic            bg_sop,
  input  logic            bg_eop,
  input  logic            bg_valid,
  output logic            bg_ready,
  output logic [3*CW-1:0] out_data,
  output logic            out_sop,
  output logic            out_eop,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            key_en,
  input  logic [CW-1:0]   key_g_min,
  input  logic [CW-1:0]   key_margin,
  output logic            sync_err
`ifdef CHROMA_KEY_STATS_EN
  ,
  output logic [31:0]     keyed_count,
  output logic            count_valid
`endif
);
  if (PIPE_LAT != 2) begin : g_lat_chk
    $error("chroma_key_mixer: PIPE_LAT must be 2");
  end
  typedef enum logic [2:0] {S_HDR, S_VID, S_CTL, S_RSY_BG, S_RSY_FG} state_t;
  state_t state, nxt, join_nxt;
  logic live, load, ld_key, err, hit, both, s1_adv, s2_adv;
  logic s1_valid, s1_sop, s1_eop, s1_key;
  logic [3*CW-1:0] s1_fg, s1_bg;
  logic [CW-1:0] r, g, b;
  assign {r, g, b} = fg_data;
  // 9-bit sums so a large R/B plus margin cannot wrap into a false key
  assign hit = g >= key_g_min && {1'b0, g} >= {1'b0, r} + {1'b0, key_margin}
            && {1'b0, g} >= {1'b0, b} + {1'b0, key_margin};
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign both = fg_valid && bg_valid;
  assign join_nxt = (fg_eop && bg_eop) ? S_HDR : fg_eop ? S_RSY_BG : bg_eop ? S_RSY_FG
                  : state != S_HDR ? state : fg_data[3:0] == 4'd0 ? S_VID : S_CTL;
  // live holds both readies low until the first clock after reset release
  always_comb begin
    fg_ready = 1'b0;
    bg_ready = 1'b0;
    load = 1'b0;
    ld_key = 1'b0;
    err = 1'b0;
    nxt = state;
    if (live)
      case (state)
        S_HDR:
          if (both && fg_sop && bg_sop) begin
            if (fg_data[3:0] != bg_data[3:0]) begin
              bg_ready = 1'b1;
              err = 1'b1;
              nxt = bg_eop ? S_HDR : S_RSY_BG;
            end else if (s1_adv) begin
              fg_ready = 1'b1;
              bg_ready = 1'b1;
              load = 1'b1;
              err = fg_eop != bg_eop;
              nxt = join_nxt;
            end
          end else begin
            fg_ready = fg_valid && !fg_sop;
            bg_ready = bg_valid && !bg_sop;
            err = fg_ready || bg_ready;
          end
        S_VID, S_CTL:
          if (both && s1_adv) begin
            fg_ready = 1'b1;
            bg_ready = 1'b1;
            load = 1'b1;
            ld_key = state == S_VID && key_en && hit;
            err = fg_eop != bg_eop;
            nxt = join_nxt;
          end
        S_RSY_BG: begin
          bg_ready = bg_valid;
          nxt = (bg_valid && bg_eop) ? S_HDR : state;
        end
        S_RSY_FG:
          if (fg_valid && s1_adv) begin
            fg_ready = 1'b1;
            load = 1'b1;
            nxt = fg_eop ? S_HDR : state;
          end
        default: nxt = S_HDR;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_HDR;
      live <= 1'b0;
      sync_err <= 1'b0;
      s1_valid <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
      s1_key <= 1'b0;
      s1_fg <= '0;
      s1_bg <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_data <= '0;
    end else begin
      state <= nxt;
      live <= 1'b1;
      sync_err <= sync_err || err;
      if (s1_adv) s1_valid <= load;
      if (load) begin
        s1_fg <= fg_data;
        s1_bg <= bg_data;
        s1_sop <= fg_sop;
        s1_eop <= fg_eop;
        s1_key <= ld_key;
      end
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out_data <= s1_key ? s1_bg : s1_fg;
        out_sop <= s1_sop;
        out_eop <= s1_eop;
      end
    end
`ifdef CHROMA_KEY_STATS_EN
  logic pkt_vid, s1_vid, s2_vid, s2_key;
  logic [31:0] cnt, cnt_nx;
  assign cnt_nx = (s2_key && cnt != '1) ? cnt + 32'd1 : cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pkt_vid <= 1'b0;
      s1_vid <= 1'b0;
      s2_vid <= 1'b0;
      s2_key <= 1'b0;
      cnt <= '0;
      keyed_count <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (load && state == S_HDR) pkt_vid <= fg_data[3:0] == 4'd0;
      if (load) s1_vid <= state == S_HDR ? fg_data[3:0] == 4'd0 : pkt_vid;
      if (s2_adv && s1_valid) begin
        s2_vid <= s1_vid;
        s2_key <= s1_key;
      end
      if (out_valid && out_ready) begin
        cnt <= (s2_vid && out_eop) ? '0 : cnt_nx;
        if (s2_vid && out_eop) begin
          keyed_count <= cnt_nx;
          count_valid <= 1'b1;
        end
      end
    end
`endif
endmodule
